// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RISC-V divide/remainder output stage:
//   - op_e      : DIV / DIVU / REM / REMU encoding of op_i
//   - state_e   : sequencer states IDLE, CALC, FIX, DONE
//   - AB_*      : bit positions inside the 6-bit operand status vector
//                 {Bm1, B1, B0, Am1, A1, A0}
//   - DIV0_Q    : quotient returned for a zero divisor
//   - INT_MIN   : most negative 32-bit value (signed overflow operand/result)
//   - helpers   : signedness test of an op and 32-bit two's complement
// ---------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int AB_A0  = 0;
  localparam int AB_A1  = 1;
  localparam int AB_AM1 = 2;
  localparam int AB_B0  = 3;
  localparam int AB_B1  = 4;
  localparam int AB_BM1 = 5;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Bit 0 of the op code distinguishes unsigned (1) from signed (0) ops.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Bit 1 of the op code selects the remainder instead of the quotient.
  function automatic logic is_rem_op(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic [31:0] negate(input logic [31:0] value);
    return ~value + 32'd1;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// ---------------------------------------------------------------------------
// muldiv_div_step
// One combinational restoring-division iteration.
//   rem          in  32  partial remainder from the previous iteration
//   dividend_bit in  1   next dividend bit, MSB first
//   divisor      in  32  divisor magnitude (or raw value for unsigned ops)
//   rem_next     out 32  partial remainder after this iteration
//   quo_bit      out 1   quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module muldiv_div_step (
  input  logic [31:0] rem,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        quo_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        borrow;
  logic        unused_diff_msb;

  assign shifted = {rem, dividend_bit};

  // The borrow out of the 33-bit subtraction is the sign of the difference.
  assign {borrow, diff} = {1'b0, shifted} - {2'b00, divisor};

  assign quo_bit = ~borrow;

  // Because the incoming remainder is always below the divisor, both the
  // difference and the restored value fit in 32 bits; bit 32 is always zero.
  assign rem_next = borrow ? shifted[31:0] : diff[31:0];

  assign unused_diff_msb = diff[32];

endmodule

// File: rtl/muldiv_out.sv
// ---------------------------------------------------------------------------
// muldiv_out
// Sequential 32-bit RISC-V divide/remainder unit (DIV, DIVU, REM, REMU)
// working on pre-conditioned operands. Special cases (divide by zero,
// signed overflow, divide by one) finish one cycle after acceptance; all
// other operations run 32 restoring iterations followed by a sign fix-up.
//   clk_i        in  1   clock, rising edge
//   reset_i      in  1   asynchronous active-low reset
//   start_i      in  1   request strobe, honoured only in IDLE
//   op_i         in  2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i   in  32  magnitude of rs1 for signed ops, raw rs1 otherwise
//   divisor_i    in  32  magnitude of rs2 for signed ops, raw rs2 otherwise
//   sign_a_i     in  1   bit 31 of raw rs1
//   sign_b_i     in  1   bit 31 of raw rs2
//   ab_status_i  in  6   {Bm1,B1,B0,Am1,A1,A0} operand flags
//   flush_i      in  1   abort any operation in progress
//   busy_o       out 1   high whenever the unit is not IDLE
//   valid_o      out 1   result_o valid, high only in DONE
//   ready_i      in  1   consumer accepts the result with valid_o
//   result_o     out 32  registered quotient or remainder
// ---------------------------------------------------------------------------
module muldiv_out
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        sign_a_i,
  input  logic        sign_b_i,
  input  logic [5:0]  ab_status_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  state_e      state;
  logic [5:0]  count;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] div_q;
  logic [1:0]  op_q;
  logic        sign_a_q;
  logic        sign_b_q;

  logic        signed_in;
  logic [31:0] raw_a;
  logic        div_zero;
  logic        overflow;
  logic        div_one;
  logic        special;
  logic [31:0] special_res;

  logic [31:0] rem_next;
  logic        quo_bit;

  logic        signed_q;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_res;

  // The A-side flags describe the dividend; no shortcut needs them here.
  logic        unused_a_flags;
  assign unused_a_flags = ^ab_status_i[AB_AM1:AB_A0];

  // Special-case detection on the incoming request. These signals only
  // feed registers loaded on the accepting edge, so result_o stays free of
  // any combinational path from the inputs.
  assign signed_in = is_signed_op(op_i);
  assign raw_a     = (signed_in && sign_a_i) ? negate(dividend_i) : dividend_i;
  assign div_zero  = ab_status_i[AB_B0];
  assign overflow  = signed_in && ab_status_i[AB_BM1] && sign_a_i &&
                     (dividend_i == INT_MIN);
  assign div_one   = ab_status_i[AB_B1];
  assign special   = div_zero || overflow || div_one;

  // Shortcut results with priority divide-by-zero, then overflow, then
  // divide-by-one. A zero divisor leaves rs1 as the remainder, and
  // divide-by-one returns rs1 as the quotient.
  always_comb begin
    special_res = 32'd0;
    if (div_zero) begin
      special_res = is_rem_op(op_i) ? raw_a : DIV0_Q;
    end else if (overflow) begin
      special_res = is_rem_op(op_i) ? 32'd0 : INT_MIN;
    end else if (div_one) begin
      special_res = is_rem_op(op_i) ? 32'd0 : raw_a;
    end
  end

  // One restoring iteration. The quotient register doubles as the dividend
  // shift register: its MSB is the next dividend bit, and the new quotient
  // bit enters at the LSB.
  muldiv_div_step u_div_step (
    .rem          (rem_q),
    .dividend_bit (quo_q[31]),
    .divisor      (div_q),
    .rem_next     (rem_next),
    .quo_bit      (quo_bit)
  );

  // Sign restoration: the quotient is negative when the operand signs
  // differ, and the remainder takes the sign of the dividend.
  assign signed_q = is_signed_op(op_q);
  assign quo_fix  = (signed_q && (sign_a_q ^ sign_b_q)) ? negate(quo_q) : quo_q;
  assign rem_fix  = (signed_q && sign_a_q) ? negate(rem_q) : rem_q;
  assign fix_res  = is_rem_op(op_q) ? rem_fix : quo_fix;

  // Sequencer with registered busy/valid/result. flush_i outranks every
  // other request. In DONE, result_o is only rewritten when a new operation
  // finishes, so it stays stable while the consumer stalls.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      count    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      div_q    <= 32'd0;
      op_q     <= 2'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= 32'd0;
    end else if (flush_i) begin
      state   <= IDLE;
      count   <= 6'd0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            op_q     <= op_i;
            sign_a_q <= sign_a_i;
            sign_b_q <= sign_b_i;
            div_q    <= divisor_i;
            quo_q    <= dividend_i;
            rem_q    <= 32'd0;
            count    <= 6'd0;
            busy_o   <= 1'b1;
            if (special) begin
              result_o <= special_res;
              valid_o  <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[30:0], quo_bit};
          if (count == 6'd31) begin
            count <= 6'd0;
            state <= FIX;
          end else begin
            count <= count + 6'd1;
          end
        end

        FIX: begin
          result_o <= fix_res;
          valid_o  <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_out.sv
// ---------------------------------------------------------------------------
// tb_muldiv_out
// Self-checking bench for muldiv_out. Raw rs1/rs2 values are conditioned
// here (magnitudes, signs, status flags) and every result is predicted from
// the RISC-V division rules using plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_muldiv_out;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        sign_a;
  logic        sign_b;
  logic [5:0]  ab_status;
  logic        flush;
  logic        busy;
  logic        valid;
  logic        ready;
  logic [31:0] result;

  int vectors;
  int miscompares;

  muldiv_out dut (
    .clk_i       (clk),
    .reset_i     (reset_n),
    .start_i     (start),
    .op_i        (op),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .sign_a_i    (sign_a),
    .sign_b_i    (sign_b),
    .ab_status_i (ab_status),
    .flush_i     (flush),
    .busy_o      (busy),
    .valid_o     (valid),
    .ready_i     (ready),
    .result_o    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something waits forever.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension division semantics on raw operands.
  function automatic logic [31:0] refResult(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      2'b01: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      2'b10: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Shortcut cases answer one cycle after acceptance, everything else 34.
  function automatic int refLatency(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    if (b == 0 || b == 1) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Drive a conditioned request for raw operands rs1/rs2 and pulse start
  // across one rising edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] rs1,
                        input logic [31:0] rs2);
    logic sgn;
    @(negedge clk);
    sgn       = ~o[0];
    op        = o;
    sign_a    = rs1[31];
    sign_b    = rs2[31];
    dividend  = (sgn && rs1[31]) ? -rs1 : rs1;
    divisor   = (sgn && rs2[31]) ? -rs2 : rs2;
    ab_status = {rs2 == 32'hFFFF_FFFF, rs2 == 32'd1, rs2 == 32'd0,
                 rs1 == 32'hFFFF_FFFF, rs1 == 32'd1, rs1 == 32'd0};
    start     = 1'b1;
    @(posedge clk);
    #1 start  = 1'b0;
  endtask

  // Full transaction: latency, result, busy, stall in DONE with ignored
  // start pulses, then hand-off with a simultaneous start that must be
  // ignored too.
  task automatic applyStimulus(input string tag, input logic [1:0] o,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input int hold);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    logic        busy_all;
    logic        hold_ok;
    exp_res  = refResult(o, rs1, rs2);
    exp_lat  = refLatency(o, rs1, rs2);
    launch(o, rs1, rs2);
    lat      = 0;
    busy_all = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      busy_all = busy_all & busy;
      if (valid) begin
        lat = k;
        break;
      end
    end
    checkOutput({tag, " latency"}, lat, exp_lat);
    checkOutput({tag, " result"}, result, exp_res);
    checkOutput({tag, " busy"}, {31'd0, busy_all}, 32'd1);
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        start    = (i % 2 == 0);
        dividend = $urandom;
        @(negedge clk);
        if (result !== exp_res || valid !== 1'b1 || busy !== 1'b1) hold_ok = 1'b0;
      end
      start = 1'b0;
      checkOutput({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
    end
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    start = 1'b0;
    checkOutput({tag, " release"}, {30'd0, busy, valid}, 32'd0);
    @(negedge clk);
    checkOutput({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Watch for a stray valid over a fixed window.
  task automatic expectSilence(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen = seen | valid;
    end
    checkOutput(tag, {31'd0, seen}, 32'd0);
  endtask

  function automatic logic [31:0] pickOperand(input bit allow_zero);
    case ($urandom_range(0, 7))
      0: return allow_zero ? 32'd0 : 32'd3;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    op          = 2'b00;
    dividend    = 32'd0;
    divisor     = 32'd0;
    sign_a      = 1'b0;
    sign_b      = 1'b0;
    ab_status   = 6'd0;
    flush       = 1'b0;
    ready       = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset state", {busy, valid, 30'd0} | result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed cases");
    applyStimulus("DIV -7/2",          2'b00, -32'sd7, 32'd2, 0);
    applyStimulus("REM -7/2",          2'b10, -32'sd7, 32'd2, 0);
    applyStimulus("DIVU 100/7",        2'b01, 32'd100, 32'd7, 5);
    applyStimulus("REMU 100/7",        2'b11, 32'd100, 32'd7, 0);
    applyStimulus("DIV 5/0",           2'b00, 32'd5, 32'd0, 0);
    applyStimulus("REM -5/0",          2'b10, -32'sd5, 32'd0, 5);
    applyStimulus("DIV min/-1",        2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus("REM min/-1",        2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus("DIVU min/all1",     2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus("DIV -9/1",          2'b00, -32'sd9, 32'd1, 0);
    applyStimulus("DIV 9/-2",          2'b00, 32'd9, -32'sd2, 0);
    applyStimulus("REM 9/-2",          2'b10, 32'd9, -32'sd2, 0);

    $display("[TB] flush during CALC");
    launch(2'b01, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ready = 1'b0;
    checkOutput("flush idle", {30'd0, busy, valid}, 32'd0);
    expectSilence("flush no valid");
    applyStimulus("after flush", 2'b01, 32'd100, 32'd7, 0);

    $display("[TB] reset mid-CALC and mid-DONE");
    launch(2'b00, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("reset calc flags", {30'd0, busy, valid}, 32'd0);
    checkOutput("reset calc result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    expectSilence("reset calc no valid");
    launch(2'b10, -32'sd5, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("reset done flags", {30'd0, busy, valid}, 32'd0);
    checkOutput("reset done result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    expectSilence("reset done no valid");

    $display("[TB] randomized cases");
    for (int n = 0; n < 40; n++) begin
      applyStimulus("random", 2'($urandom_range(0, 3)), pickOperand(1'b0),
                    pickOperand(1'b1), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
